// File: rtl/rgb_pwm_driver.sv
// Three-channel 8-bit PWM LED driver with period-aligned, double-buffered duty update.
// Colours are captured into a pending buffer and take effect only at the period wrap.
module rgb_pwm_driver #(
    parameter int PRESCALE = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [23:0] rgb,
    output logic        led_r,
    output logic        led_g,
    output logic        led_b,
    output logic        period_start
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(PRESCALE - 1);

    logic [PW-1:0] r_pre_cnt;
    logic [7:0]    r_pwm_cnt;
    logic [23:0]   r_pending;
    logic [7:0]    r_duty_r;
    logic [7:0]    r_duty_g;
    logic [7:0]    r_duty_b;
    logic          w_tick;
    logic          w_wrap;

    assign w_tick = (r_pre_cnt == PRE_MAX);
    assign w_wrap = w_tick && (r_pwm_cnt == 8'hFF);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pre_cnt <= '0;
            r_pwm_cnt <= '0;
        end else begin
            r_pre_cnt <= w_tick ? '0 : r_pre_cnt + 1'b1;
            if (w_tick)
                r_pwm_cnt <= r_pwm_cnt + 8'd1;
        end
    end

    // Duties latch the pending value from before this edge, so a
    // simultaneous capture waits one full period.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pending    <= '0;
            r_duty_r     <= '0;
            r_duty_g     <= '0;
            r_duty_b     <= '0;
            period_start <= 1'b0;
        end else begin
            if (enable)
                r_pending <= rgb;
            if (w_wrap) begin
                r_duty_r <= r_pending[23:16];
                r_duty_g <= r_pending[15:8];
                r_duty_b <= r_pending[7:0];
            end
            period_start <= w_wrap;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            led_r <= 1'b0;
            led_g <= 1'b0;
            led_b <= 1'b0;
        end else begin
            led_r <= (r_pwm_cnt < r_duty_r);
            led_g <= (r_pwm_cnt < r_duty_g);
            led_b <= (r_pwm_cnt < r_duty_b);
        end
    end

endmodule

// File: tb/tb_rgb_pwm_driver.sv
// Bench for rgb_pwm_driver: cycle model of period/duty rules plus
// directed per-period high-time counts.
module tb_rgb_pwm_driver;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [23:0] rgb;
    logic        led_r;
    logic        led_g;
    logic        led_b;
    logic        period_start;

    int tests = 0;
    int fails = 0;

    // Reference state: edges since reset, pending word, active duties
    int          m_cyc;
    logic [23:0] m_pend;
    logic [23:0] m_duty;
    logic        m_r, m_g, m_b, m_ps;
    bit          m_valid = 0;

    rgb_pwm_driver #(.PRESCALE(1)) dut (
        .clk(clk),
        .rst(rst),
        .enable(enable),
        .rgb(rgb),
        .led_r(led_r),
        .led_g(led_g),
        .led_b(led_b),
        .period_start(period_start)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        int ph;
        if (rst) begin
            m_cyc  = 0;
            m_pend = '0;
            m_duty = '0;
            m_r = 0; m_g = 0; m_b = 0; m_ps = 0;
            m_valid = 1;
        end else begin
            ph   = m_cyc % 256;
            m_r  = (ph < int'(m_duty[23:16]));
            m_g  = (ph < int'(m_duty[15:8]));
            m_b  = (ph < int'(m_duty[7:0]));
            m_ps = (ph == 255);
            if (ph == 255) m_duty = m_pend;
            if (enable) m_pend = rgb;
            m_cyc++;
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        if (m_valid) begin
            chk("model_led_r", 32'(led_r), 32'(m_r));
            chk("model_led_g", 32'(led_g), 32'(m_g));
            chk("model_led_b", 32'(led_b), 32'(m_b));
            chk("model_period_start", 32'(period_start), 32'(m_ps));
        end
    endtask

    task automatic sync_ps();
        int n = 0;
        while (n < 600) begin
            cycle();
            n++;
            if (period_start === 1'b1) break;
        end
        chk("sync_timeout", 32'(n < 600), 32'd1);
    endtask

    task automatic measure(input int chg_at, input logic [23:0] chg_rgb,
                           output int hr, output int hg, output int hb,
                           output int ps);
        hr = 0; hg = 0; hb = 0; ps = 0;
        for (int i = 0; i < 256; i++) begin
            if (i == chg_at) rgb = chg_rgb;
            cycle();
            hr += int'(led_r);
            hg += int'(led_g);
            hb += int'(led_b);
            ps += int'(period_start);
        end
    endtask

    task automatic check_period(input string tag, input int chg_at,
                                input logic [23:0] chg_rgb,
                                input int er, input int eg, input int eb);
        int hr, hg, hb, ps;
        measure(chg_at, chg_rgb, hr, hg, hb, ps);
        chk({tag, "_r_high"}, 32'(hr), 32'(er));
        chk({tag, "_g_high"}, 32'(hg), 32'(eg));
        chk({tag, "_b_high"}, 32'(hb), 32'(eb));
        chk({tag, "_ps_count"}, 32'(ps), 32'd1);
    endtask

    initial begin
        int n;
        rst = 1; enable = 1; rgb = 24'hFFFFFF;

        // 1: reset and first empty period
        cycle();
        cycle();
        rst = 0;
        for (int i = 0; i < 255; i++) begin
            cycle();
            chk("first_period_quiet",
                32'(led_r | led_g | led_b | period_start), 32'd0);
        end
        cycle();
        chk("first_wrap_256", 32'(period_start), 32'd1);

        // 2: nominal duties
        rgb = 24'h4080C0;
        sync_ps();
        sync_ps();
        check_period("duty_p1", -1, rgb, 64, 128, 192);
        check_period("duty_p2", -1, rgb, 64, 128, 192);

        // 3: extremes
        rgb = 24'h00FF00;
        sync_ps();
        sync_ps();
        check_period("extreme", -1, rgb, 0, 255, 0);

        // 4: mid-period change must not disturb current period
        rgb = 24'h4080C0;
        sync_ps();
        sync_ps();
        check_period("glitch_old", 100, 24'hC080C0, 64, 128, 192);
        check_period("glitch_new", -1, rgb, 192, 128, 192);

        // 5: enable hold, then single-cycle capture
        enable = 0;
        rgb = 24'hFF0000;
        check_period("hold_p1", -1, rgb, 192, 128, 192);
        check_period("hold_p2", -1, rgb, 192, 128, 192);
        enable = 1;
        cycle();
        enable = 0;
        rgb = 24'h123456;
        sync_ps();
        check_period("captured", -1, rgb, 255, 0, 0);

        // random colours, checked by the cycle model
        enable = 1;
        for (int k = 0; k < 6; k++) begin
            rgb = 24'($urandom);
            enable = 1'($urandom_range(0, 1));
            for (int j = 0; j < int'($urandom_range(50, 400)); j++) begin
                cycle();
                if ($urandom_range(0, 15) == 0) enable = ~enable;
            end
        end
        enable = 1;
        rgb = 24'h80A0F0;
        sync_ps();
        sync_ps();

        // 6: reset mid-period
        for (int i = 0; i < 100; i++) cycle();
        rst = 1;
        cycle();
        chk("midrst_outs",
            32'(led_r | led_g | led_b | period_start), 32'd0);
        rst = 0;
        n = 0;
        while (n < 600) begin
            cycle();
            n++;
            if (period_start === 1'b1) break;
        end
        chk("midrst_restart_256", 32'(n), 32'd256);
        check_period("post_rst", -1, rgb, 128, 160, 240);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
